// File: rtl/uart_rx.sv
// uart_rx: oversampled asynchronous serial receiver.
// One start bit, DATA_BITS data bits (LSB first) and one stop bit. Each bit is
// sampled once, near its middle, on a tick_en strobe.
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle; waiting for rx_s low on a tick
// START     | half-bit check of the start bit; a high sample is a glitch
// DATA      | sampling data bits at mid-bit, shifting in LSB first
// PARITY    | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP      | sampling the stop bit; publishes data or flags a framing error
// WAIT_IDLE | after a framing error; waiting for the line to return high
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [BW-1:0]        bit_idx, bit_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt;
  logic                 ferr_nxt;
  logic                 rx_meta, rx_s;

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_nxt;
  logic perr_nxt;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data        <= '0;
      valid       <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_nxt;
      shreg       <= shreg_nxt;
      data        <= data_nxt;
      valid       <= valid_nxt;
      framing_err <= ferr_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity verdict held from the parity bit until the stop bit, plus its pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_nxt;
      parity_err <= perr_nxt;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Next-state and datapath decode; nothing moves except on tick_en cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    data_nxt  = data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
    perr_nxt    = 1'b0;
`endif
    if (tick_en) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            cnt_nxt   = '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt_nxt = '0;
            if (rx_s) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = DATA;
              bit_nxt   = '0;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_FULL) begin
            cnt_nxt   = '0;
            shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == BIT_LAST) begin
              bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              bit_nxt = bit_idx + BW'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_FULL) begin
            cnt_nxt     = '0;
            par_bad_nxt = (^shreg) ^ rx_s;
            state_nxt   = STOP;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt_nxt = '0;
            if (rx_s) begin
              state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                perr_nxt = 1'b1;
              end else begin
                data_nxt  = shreg;
                valid_nxt = 1'b1;
              end
`else
              data_nxt  = shreg;
              valid_nxt = 1'b1;
`endif
            end else begin
              // A low stop bit may be the start of a break; wait for the line
              // to go high so a long break reports only once.
              ferr_nxt  = 1'b1;
              state_nxt = WAIT_IDLE;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with OVERSAMPLE=16, DATA_BITS=8 and
// tick_en every 4 clk (one bit = 64 clk). Inputs change and outputs are
// observed on the falling clock edge.
module tb_uart_rx;

  localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int MID_OFF = (FBITS - 1) * BIT_CLK + BIT_CLK / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic       tick_en;
  logic [7:0] data;
  logic       valid, framing_err, parity_err, busy;

  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;

  int vcnt = 0, fcnt = 0, pcnt = 0, viol = 0;
  logic [7:0] last_vdata = 8'h00;
  int unsigned fall_cyc = 0;
  int unsigned start_cyc = 0;
  logic pv = 1'b0, pf = 1'b0, pp = 1'b0;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_en     (tick_en),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .framing_err (framing_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign tick_en = (cyc[1:0] == 2'd3);

  // Pulse monitor: counts pulses and notes any pulse longer than one clk or
  // any overlap of valid and framing_err.
  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      last_vdata = data;
    end
    if (framing_err) fcnt++;
    if (parity_err) pcnt++;
    if (pv && valid) viol++;
    if (pf && framing_err) viol++;
    if (pp && parity_err) viol++;
    if (valid && framing_err) viol++;
    if (pv && !valid) fall_cyc = cyc;
    pv = valid;
    pf = framing_err;
    pp = parity_err;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Starts the start bit two clk before a tick so each sample lands just
  // after the bit's midpoint; must be called at a falling edge.
  task automatic align();
    while (cyc[1:0] != 2'd1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    align();
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop);
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * BIT_CLK) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par_flip;
    logic       stop;
    int         exp_v;
    int         exp_f;
    int         exp_p;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int v0, f0, p0, fall_off;
    logic [7:0] d0;

    vecs.push_back('{8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5});
    vecs.push_back('{8'h00, 1'b0, 1'b1, 1, 0, 0, 8'h00});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1, 0, 0, 8'hFF});
    vecs.push_back('{8'h5A, 1'b0, 1'b0, 0, 1, 0, 8'hFF});
    vecs.push_back('{8'h81, 1'b0, 1'b1, 1, 0, 0, 8'h81});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5});
    vecs.push_back('{8'hA5, 1'b1, 1'b1, 0, 0, 1, 8'hA5});
    vecs.push_back('{8'h07, 1'b1, 1'b1, 0, 0, 1, 8'hA5});
`endif

    // Reset state.
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", int'({data, valid, framing_err, parity_err, busy}), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Table of single frames.
    for (int i = 0; i < vecs.size(); i++) begin
      v0 = vcnt; f0 = fcnt; p0 = pcnt;
      send_frame(vecs[i].d, vecs[i].par_flip, vecs[i].stop);
      idle(2);
      check($sformatf("vec%0d_valid_count", i), vcnt - v0, vecs[i].exp_v);
      check($sformatf("vec%0d_ferr_count", i), fcnt - f0, vecs[i].exp_f);
      check($sformatf("vec%0d_perr_count", i), pcnt - p0, vecs[i].exp_p);
      check($sformatf("vec%0d_data", i), int'(data), int'(vecs[i].exp_data));
      check($sformatf("vec%0d_busy", i), int'(busy), 0);
      if (i == 0) begin
        fall_off = int'(fall_cyc - start_cyc) - MID_OFF;
        check("valid_fall_window", int'(fall_off >= 2 && fall_off <= 6), 1);
      end
    end

    // Short low glitch on an idle line.
    d0 = data;
    v0 = vcnt; f0 = fcnt; p0 = pcnt;
    align();
    rx = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_busy", int'(busy), 1);
    idle(2);
    check("glitch_no_valid", vcnt - v0, 0);
    check("glitch_no_ferr", fcnt - f0, 0);
    check("glitch_data", int'(data), int'(d0));
    check("glitch_busy_after", int'(busy), 0);

    // Bad stop bit followed by a long break, then a good frame.
    v0 = vcnt; f0 = fcnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20 * BIT_CLK) @(negedge clk);
    idle(2);
    check("break_ferr_count", fcnt - f0, 1);
    check("break_no_valid", vcnt - v0, 0);
    v0 = vcnt;
    send_frame(8'h81, 1'b0, 1'b1);
    idle(1);
    check("after_break_valid", vcnt - v0, 1);
    check("after_break_data", int'(last_vdata), 8'h81);

    // Back-to-back frames with no idle between them.
    v0 = vcnt;
    send_frame(8'h55, 1'b0, 1'b1);
    check("b2b_first_valid", vcnt - v0, 1);
    check("b2b_first_data", int'(last_vdata), 8'h55);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(1);
    check("b2b_total_valid", vcnt - v0, 2);
    check("b2b_second_data", int'(last_vdata), 8'hFF);

    // Reset in the middle of data bit 4 of 0x0F.
    v0 = vcnt; f0 = fcnt; p0 = pcnt;
    align();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1 check("midframe_reset_outputs", int'({data, valid, framing_err, parity_err, busy}), 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("midframe_reset_no_pulse", (vcnt - v0) + (fcnt - f0) + (pcnt - p0), 0);
    check("midframe_reset_busy", int'(busy), 0);
    send_frame(8'h12, 1'b0, 1'b1);
    idle(1);
    check("after_reset_valid", vcnt - v0, 1);
    check("after_reset_data", int'(data), 8'h12);

    check("pulse_shape_violations", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
